// File: rtl/clk_div_multi.sv
// clk_div_multi: NCH independent programmable clock dividers sharing one write port.
//   Every channel counts enabled clk_in cycles. Each time its counter reaches the
//   active divisor it toggles clk_out and pulses tick, so one half-period lasts
//   act+1 enabled cycles.
//
//   Divisor writes (wr_en/wr_ch/wr_div) are activated in one of two ways:
//     - Default build: the write goes into a shadow register and raises pend. It
//       becomes the active divisor at the next toggle, so periods stay glitch-free.
//     - With macro CLK_DIV_IMMEDIATE_LOAD_EN defined: the write loads the active
//       divisor directly and restarts the counter. clk_out is left unchanged.
//
// Ports:
//   clk_in              system clock; all state changes on its rising edge
//   rst                 asynchronous, active-high reset
//   en[NCH]             per-channel run enable
//   wr_en, wr_ch, wr_div  one-cycle divisor write; writes to wr_ch >= NCH are ignored
//   clk_out[NCH]        divided square wave; reset value is 1
//   tick[NCH]           one-cycle pulse registered together with each toggle
//   pend[NCH]           a written divisor is waiting for activation (shadow mode only)
module clk_div_multi #(
  parameter int unsigned WIDTH       = 24,
  parameter int unsigned NCH         = 2,
  parameter int unsigned CH_W        = 1,
  parameter int unsigned DIV_DEFAULT = 12499999
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic [NCH-1:0]   en,
  input  logic             wr_en,
  input  logic [CH_W-1:0]  wr_ch,
  input  logic [WIDTH-1:0] wr_div,
  output logic [NCH-1:0]   clk_out,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   pend
);

  localparam int unsigned SEL_W = CH_W + 1;

  logic [WIDTH-1:0] cnt_q [NCH];
  logic [WIDTH-1:0] cnt_d [NCH];
  logic [WIDTH-1:0] act_q [NCH];
  logic [WIDTH-1:0] act_d [NCH];
  logic [WIDTH-1:0] shd_q [NCH];
  logic [WIDTH-1:0] shd_d [NCH];
  logic [NCH-1:0]   pend_q, pend_d;
  logic [NCH-1:0]   clk_out_q, clk_out_d;
  logic [NCH-1:0]   tick_q, tick_d;

  logic             wr_valid_c;
  logic [NCH-1:0]   wr_hit_c;
  logic [NCH-1:0]   term_c;

  // A write is valid only when the channel select addresses an existing channel.
  assign wr_valid_c = wr_en && ({1'b0, wr_ch} < SEL_W'(NCH));

  // Per-channel write decode and terminal-count detect.
  always_comb begin
    wr_hit_c = '0;
    term_c   = '0;
    for (int i = 0; i < NCH; i++) begin
      wr_hit_c[i] = wr_valid_c && (wr_ch == CH_W'(i));
      term_c[i]   = en[i] && (cnt_q[i] == act_q[i]);
    end
  end

  // Next-state logic for every channel.
  always_comb begin
    cnt_d     = cnt_q;
    act_d     = act_q;
    shd_d     = shd_q;
    pend_d    = pend_q;
    clk_out_d = clk_out_q;
    tick_d    = '0;
    for (int i = 0; i < NCH; i++) begin
`ifdef CLK_DIV_IMMEDIATE_LOAD_EN
      // A write restarts the half-period with the new divisor and takes priority
      // over a coinciding terminal count.
      if (wr_hit_c[i]) begin
        act_d[i] = wr_div;
        shd_d[i] = wr_div;
        cnt_d[i] = '0;
      end else if (term_c[i]) begin
        cnt_d[i]     = '0;
        clk_out_d[i] = ~clk_out_q[i];
        tick_d[i]    = 1'b1;
      end else if (en[i]) begin
        cnt_d[i] = cnt_q[i] + WIDTH'(1);
      end
`else
      if (term_c[i]) begin
        cnt_d[i]     = '0;
        clk_out_d[i] = ~clk_out_q[i];
        tick_d[i]    = 1'b1;
        pend_d[i]    = 1'b0;
        // A write arriving on the boundary goes straight to the active divisor.
        if (wr_hit_c[i]) begin
          act_d[i] = wr_div;
          shd_d[i] = wr_div;
        end else if (pend_q[i]) begin
          act_d[i] = shd_q[i];
        end
      end else begin
        // Counter wraps naturally through 2^WIDTH-1 if it ever sits above act.
        if (en[i]) begin
          cnt_d[i] = cnt_q[i] + WIDTH'(1);
        end
        if (wr_hit_c[i]) begin
          shd_d[i]  = wr_div;
          pend_d[i] = 1'b1;
        end
      end
`endif
    end
  end

  // State registers.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= '0;
        act_q[i] <= WIDTH'(DIV_DEFAULT);
        shd_q[i] <= WIDTH'(DIV_DEFAULT);
      end
      pend_q    <= '0;
      clk_out_q <= '1;
      tick_q    <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= cnt_d[i];
        act_q[i] <= act_d[i];
        shd_q[i] <= shd_d[i];
      end
      pend_q    <= pend_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign clk_out = clk_out_q;
  assign tick    = tick_q;
  assign pend    = pend_q;

endmodule

// File: tb/tb_clk_div_multi.sv
// Randomized bench for clk_div_multi. A reference model tracks, for every channel,
// the number of enabled cycles left before the next toggle, together with the
// divisor-activation rules. All outputs are compared after every clock edge and
// after every asynchronous reset pulse.
module tb_clk_div_multi;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned NCH   = 2;
  localparam int unsigned CH_W  = 2;
  localparam int unsigned DDEF  = 3;

  logic             clk_in = 1'b0;
  logic             rst;
  logic [NCH-1:0]   en;
  logic             wr_en;
  logic [CH_W-1:0]  wr_ch;
  logic [WIDTH-1:0] wr_div;
  logic [NCH-1:0]   clk_out;
  logic [NCH-1:0]   tick;
  logic [NCH-1:0]   pend;

  clk_div_multi #(
    .WIDTH(WIDTH), .NCH(NCH), .CH_W(CH_W), .DIV_DEFAULT(DDEF)
  ) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .en     (en),
    .wr_en  (wr_en),
    .wr_ch  (wr_ch),
    .wr_div (wr_div),
    .clk_out(clk_out),
    .tick   (tick),
    .pend   (pend)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  int left  [NCH];
  int m_act [NCH];
  int m_shd [NCH];
  bit m_clk [NCH];
  bit m_tick[NCH];
  bit m_pend[NCH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      left[i]   = DDEF + 1;
      m_act[i]  = DDEF;
      m_shd[i]  = DDEF;
      m_clk[i]  = 1'b1;
      m_tick[i] = 1'b0;
      m_pend[i] = 1'b0;
    end
  endtask

  // Apply one rising edge to the model using the inputs currently driven.
  task automatic model_edge();
    for (int i = 0; i < NCH; i++) begin
      bit hit;
      int nact;
      hit       = wr_en && (int'(wr_ch) < NCH) && (int'(wr_ch) == i);
      m_tick[i] = 1'b0;
`ifdef CLK_DIV_IMMEDIATE_LOAD_EN
      if (hit) begin
        m_act[i] = int'(wr_div);
        m_shd[i] = int'(wr_div);
        left[i]  = int'(wr_div) + 1;
      end else if (en[i]) begin
        left[i]--;
        if (left[i] == 0) begin
          m_clk[i]  = ~m_clk[i];
          m_tick[i] = 1'b1;
          left[i]   = m_act[i] + 1;
        end
      end
`else
      if (en[i]) left[i]--;
      if (en[i] && left[i] == 0) begin
        m_clk[i]  = ~m_clk[i];
        m_tick[i] = 1'b1;
        nact      = hit ? int'(wr_div) : (m_pend[i] ? m_shd[i] : m_act[i]);
        if (hit) m_shd[i] = int'(wr_div);
        m_act[i]  = nact;
        left[i]   = nact + 1;
        m_pend[i] = 1'b0;
      end else if (hit) begin
        m_shd[i]  = int'(wr_div);
        m_pend[i] = 1'b1;
      end
`endif
    end
  endtask

  task automatic compare_all(input string when);
    logic [NCH-1:0] e_clk, e_tick, e_pend;
    for (int i = 0; i < NCH; i++) begin
      e_clk[i]  = m_clk[i];
      e_tick[i] = m_tick[i];
      e_pend[i] = m_pend[i];
    end
    check({when, " clk_out"}, 32'(clk_out), 32'(e_clk));
    check({when, " tick"},    32'(tick),    32'(e_tick));
    check({when, " pend"},    32'(pend),    32'(e_pend));
  endtask

  task automatic randomize_inputs(input int cyc);
    if (cyc < 40) begin
      en    = '1;
      wr_en = 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) en[i] = ($urandom_range(0, 7) != 0);
      wr_en = ($urandom_range(0, 5) == 0);
    end
    wr_ch  = CH_W'($urandom_range(0, 3));
    wr_div = ($urandom_range(0, 9) == 0) ? WIDTH'($urandom_range(0, 15))
                                         : WIDTH'($urandom_range(0, 4));
  endtask

  initial begin
    rst    = 1'b1;
    en     = '1;
    wr_en  = 1'b0;
    wr_ch  = '0;
    wr_div = '0;
    model_reset();
    #2;
    compare_all("reset");
    @(posedge clk_in);
    #1;
    compare_all("reset_held");
    rst = 1'b0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      randomize_inputs(cyc);
      @(posedge clk_in);
      model_edge();
      #1;
      compare_all("cycle");
      // Occasional reset pulse that lands entirely between two clock edges.
      if (cyc > 40 && $urandom_range(0, 149) == 0) begin
        #2 rst = 1'b1;
        #1;
        model_reset();
        compare_all("async_rst");
        #1 rst = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
